if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage of pipeline_cpu: owns the PC, drives the instruction-memory word address,
//  and loads the IF/ID pipeline register consumed by decode. Applies the stall and branch/jump redirect
//  requests issued by decode. Contains a sticky fault state for out-of-range fetch. Counts issued
//  instructions for the bench.
// PARAMETERS
//  RESET_PC    32'h0000_3000  PC after reset; byte address of IM word 0
//  IM_AW       10             IM word-address width; IM holds 2**IM_AW words
//  DELAY_SLOT  1              1: instruction after a branch executes; 0: it is squashed
// PORTS
//  clock          in   1      rising-edge clock
//  reset          in   1      synchronous, active-high reset
//  stall          in   1      decode hazard: hold PC and IF/ID
//  redirect       in   1      branch taken / jump, valid this cycle
//  redirect_pc    in   32     target byte address
//  imem_addr      out  IM_AW  IM word address = (pc - RESET_PC) >> 2
//  imem_rdata     in   32     IM word, combinational read of imem_addr
//  pc             out  32     current fetch PC
//  if_id_valid    out  1      IF/ID holds a real instruction
//  if_id_instr    out  32     fetched instruction (32'h0 = nop when invalid)
//  if_id_pc       out  32     PC of if_id_instr
//  if_id_pc4      out  32     if_id_pc + 4 (jal/branch base)
//  pc_fault       out  1      sticky: fetch left IM range
//  fetch_count    out  32     valid instructions issued to IF/ID
// BEHAVIOUR
//  - Reset (sampled on a clock edge): pc=RESET_PC; if_id_valid=0; if_id_instr, if_id_pc, if_id_pc4=0;
//    pc_fault=0; fetch_count=0; state=RUN. Reset overrides every other input.
//  - Latency: the word at pc appears in IF/ID on the next edge. One instruction per cycle when not stalled.
//  - In range: (pc - RESET_PC) < 4*2**IM_AW, 32-bit unsigned subtract. pc below RESET_PC wraps, so it is out of range.
//  - Address alignment: redirect_pc[1:0] is ignored and forced to 2'b00. pc increments by 4, mod 2**32.
//  - FSM RUN:
//      redirect=1            -> pc<=target. IF/ID loads the current fetch if DELAY_SLOT=1; otherwise IF/ID loads a bubble.
//      redirect=0, stall=1   -> pc and IF/ID hold; fetch_count holds.
//      neither               -> pc<=pc+4; IF/ID loads {1, imem_rdata, pc, pc+4}.
//      pc out of range on a loading edge -> IF/ID gets bubble; pc_fault<=1; state<=FAULT; pc holds.
//  - FSM FAULT: IF/ID loads a bubble every cycle unless stall=1; pc holds.
//      redirect to an in-range target -> pc<=target, state<=RUN. pc_fault stays 1 until reset.
//  - Bubble = {valid=0, instr=32'h0, pc=0, pc4=0}.
//  - Priority: reset > redirect > stall > normal. redirect+stall in the same cycle: redirect wins fully.
//  - fetch_count: +1 on each edge that loads if_id_valid=1; saturates at 32'hFFFF_FFFF.
//  - IF/ID outputs are registered. imem_addr is combinational from pc.
// STRUCTURE
//  - Shared package cpu_defs: RESET_PC default, INSTR_NOP=32'h0, state encoding (RUN=1'b0, FAULT=1'b1),
//    bubble constant.
//  - Sub-module ifid_reg: IF/ID register with load / hold / bubble controls, instantiated once.
//  - PC logic, FSM and counter live in if_stage.
// TESTING
//  1 reset, IM[0..3]=A,B,C,D, no stall -> cycles 1..4 IF/ID = A@3000, B@3004, C@3008, D@300C; fetch_count=4.
//  2 stall held 3 cycles while IF/ID=B@3004 -> pc stays 3008, IF/ID stays B, fetch_count unchanged; release -> C next.
//  3 redirect to 3020 while fetching 3008:
//      DELAY_SLOT=1 -> IF/ID = C@3008, then IM[8]@3020.
//      DELAY_SLOT=0 -> IF/ID = bubble, then IM[8]@3020.
//  4 redirect+stall in the same cycle, target 3010 -> pc=3010 next edge; stall ignored.
//  5 redirect to 32'h0000_0000 (below RESET_PC) -> next edge IF/ID bubble, pc_fault=1, FAULT.
//      Redirect to 3000 -> RUN, valid fetches resume, pc_fault stays 1.
//  6 reset asserted mid-run with stall=1 and redirect=1 -> next edge all outputs at reset values, pc=3000.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared definitions for the pipeline_cpu fetch path: reset PC, nop encoding,
// fetch FSM state encoding and the IF/ID record with its bubble value.
package cpu_defs;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, instr: INSTR_NOP, pc: 32'h0000_0000, pc4: 32'h0000_0000};

    // Fetch addresses are word aligned; the low two bits of any target are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's decode-control, instruction-memory and IF/ID signals.
// master = fetch stage, slave = its environment (decode, IM, bench).
interface if_stage_if #(
    parameter int IM_AW = 10
);
    logic             stall;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic [IM_AW-1:0] imem_addr;
    logic [31:0]      imem_rdata;
    logic [31:0]      pc;
    logic             if_id_valid;
    logic [31:0]      if_id_instr;
    logic [31:0]      if_id_pc;
    logic [31:0]      if_id_pc4;
    logic             pc_fault;
    logic [31:0]      fetch_count;

    modport master (
        input  stall, redirect, redirect_pc, imem_rdata,
        output imem_addr, pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc4, pc_fault, fetch_count
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_rdata,
        input  imem_addr, pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc4, pc_fault, fetch_count
    );
endinterface

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register: bubble has priority over load; neither means hold.
module ifid_reg
    import cpu_defs::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  load,
    input  logic  bubble,
    input  ifid_t d,
    output ifid_t q
);

    // IF/ID register update
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= IFID_BUBBLE;
        end else if (bubble) begin
            q <= IFID_BUBBLE;
        end else if (load) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, RUN/FAULT fetch FSM, IF/ID register
// and a saturating count of valid instructions issued to decode.
module if_stage
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IM_AW      = 10,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    if_stage_if.master bus
);

    fetch_state_e state_r, state_next_s;
    logic [31:0]  pc_r, pc_next_s;
    logic         fault_r, fault_next_s;
    logic [31:0]  count_r;
    logic         ifid_load_s, ifid_bubble_s;
    logic [31:0]  offset_s, target_s, target_offset_s;
    logic         in_range_s, target_in_range_s;
    ifid_t        ifid_d_s, ifid_q_s;

    // Unsigned subtract makes anything below RESET_PC wrap to a huge offset, i.e. out of range.
    assign offset_s          = pc_r - RESET_PC;
    assign in_range_s        = (offset_s >> (IM_AW + 2)) == 32'h0000_0000;
    assign target_s          = align_word(bus.redirect_pc);
    assign target_offset_s   = target_s - RESET_PC;
    assign target_in_range_s = (target_offset_s >> (IM_AW + 2)) == 32'h0000_0000;

    assign ifid_d_s = '{valid: 1'b1, instr: bus.imem_rdata, pc: pc_r, pc4: pc_r + 32'd4};

    // State, PC, sticky fault and issue counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_RUN;
            pc_r    <= RESET_PC;
            fault_r <= 1'b0;
            count_r <= 32'h0000_0000;
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
            fault_r <= fault_next_s;
            if (ifid_load_s && (count_r != 32'hFFFF_FFFF)) begin
                count_r <= count_r + 32'd1;
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Next-state, next-PC and IF/ID control
    always_comb begin
        state_next_s  = state_r;
        pc_next_s     = pc_r;
        fault_next_s  = fault_r;
        ifid_load_s   = 1'b0;
        ifid_bubble_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (bus.redirect || !bus.stall) begin
                    if (!in_range_s) begin
                        ifid_bubble_s = 1'b1;
                        fault_next_s  = 1'b1;
                        // A redirect out of the bad region keeps the stage running.
                        if (bus.redirect && target_in_range_s) begin
                            pc_next_s = target_s;
                        end else begin
                            state_next_s = ST_FAULT;
                        end
                    end else if (bus.redirect) begin
                        pc_next_s = target_s;
                        if (DELAY_SLOT) begin
                            ifid_load_s = 1'b1;
                        end else begin
                            ifid_bubble_s = 1'b1;
                        end
                    end else begin
                        pc_next_s   = pc_r + 32'd4;
                        ifid_load_s = 1'b1;
                    end
                end else begin
                    ifid_load_s = 1'b0;
                end
            end
            ST_FAULT: begin
                if (bus.redirect) begin
                    ifid_bubble_s = 1'b1;
                    if (target_in_range_s) begin
                        pc_next_s    = target_s;
                        state_next_s = ST_RUN;
                    end else begin
                        state_next_s = ST_FAULT;
                    end
                end else if (!bus.stall) begin
                    ifid_bubble_s = 1'b1;
                end else begin
                    ifid_bubble_s = 1'b0;
                end
            end
            default: begin
                ifid_bubble_s = 1'b1;
                state_next_s  = ST_FAULT;
            end
        endcase
    end

    ifid_reg u_ifid_reg (
        .clock  (clock),
        .reset  (reset),
        .load   (ifid_load_s),
        .bubble (ifid_bubble_s),
        .d      (ifid_d_s),
        .q      (ifid_q_s)
    );

    assign bus.imem_addr   = offset_s[IM_AW+1:2];
    assign bus.pc          = pc_r;
    assign bus.if_id_valid = ifid_q_s.valid;
    assign bus.if_id_instr = ifid_q_s.instr;
    assign bus.if_id_pc    = ifid_q_s.pc;
    assign bus.if_id_pc4   = ifid_q_s.pc4;
    assign bus.pc_fault    = fault_r;
    assign bus.fetch_count = count_r;

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage: a delay-slot instance is fully checked,
// a no-delay-slot instance on the same stimulus is checked for squashed delay slots.
module tb_if_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] mem [0:1023];
    int          n_cmp = 0;
    int          n_err = 0;

    if_stage_if #(.IM_AW(10)) b1 ();
    if_stage_if #(.IM_AW(10)) b0 ();

    assign b1.stall       = stall;
    assign b1.redirect    = redirect;
    assign b1.redirect_pc = redirect_pc;
    assign b1.imem_rdata  = mem[b1.imem_addr];
    assign b0.stall       = stall;
    assign b0.redirect    = redirect;
    assign b0.redirect_pc = redirect_pc;
    assign b0.imem_rdata  = mem[b0.imem_addr];

    if_stage #(.RESET_PC(32'h0000_3000), .IM_AW(10), .DELAY_SLOT(1'b1)) dut_ds1 (
        .clock (clock),
        .reset (reset),
        .bus   (b1)
    );

    if_stage #(.RESET_PC(32'h0000_3000), .IM_AW(10), .DELAY_SLOT(1'b0)) dut_ds0 (
        .clock (clock),
        .reset (reset),
        .bus   (b0)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        fault;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] m(input int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    function automatic void add(input logic s, input logic r, input logic [31:0] rpc,
                                input logic v, input logic [31:0] instr, input logic [31:0] ipc,
                                input logic [31:0] pc, input logic [31:0] cnt, input logic f);
        vec_t t;
        t.stall = s; t.redir = r; t.rpc = rpc; t.valid = v; t.instr = instr;
        t.ipc = ipc; t.pc = pc; t.cnt = cnt; t.fault = f;
        vq.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " pc"},        b1.pc,                 32'h0000_3000);
        chk({tag, " valid"},     32'(b1.if_id_valid),   32'h0);
        chk({tag, " instr"},     b1.if_id_instr,        32'h0);
        chk({tag, " ifpc"},      b1.if_id_pc,           32'h0);
        chk({tag, " pc4"},       b1.if_id_pc4,          32'h0);
        chk({tag, " fault"},     32'(b1.pc_fault),      32'h0);
        chk({tag, " count"},     b1.fetch_count,        32'h0);
        chk({tag, " imem_addr"}, 32'(b1.imem_addr),     32'h0);
        chk({tag, " ds0 pc"},    b0.pc,                 32'h0000_3000);
        chk({tag, " ds0 valid"}, 32'(b0.if_id_valid),   32'h0);
        chk({tag, " ds0 count"}, b0.fetch_count,        32'h0);
    endtask

    initial begin
        logic [31:0] exp_addr;
        for (int i = 0; i < 1024; i++) mem[i] = m(i);
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        @(posedge clock); #1;
        chk_reset_state("reset");
        reset = 1'b0;

        // stall, redir, rpc | valid, instr, if_id_pc, pc, count, fault   (DELAY_SLOT=1 view)
        add(0, 0, 32'h0,    1, m(0),    32'h3000, 32'h3004, 1,  0);
        add(0, 0, 32'h0,    1, m(1),    32'h3004, 32'h3008, 2,  0);
        add(1, 0, 32'h0,    1, m(1),    32'h3004, 32'h3008, 2,  0);
        add(1, 0, 32'h0,    1, m(1),    32'h3004, 32'h3008, 2,  0);
        add(1, 0, 32'h0,    1, m(1),    32'h3004, 32'h3008, 2,  0);
        add(0, 0, 32'h0,    1, m(2),    32'h3008, 32'h300C, 3,  0);
        add(0, 0, 32'h0,    1, m(3),    32'h300C, 32'h3010, 4,  0);
        add(0, 1, 32'h3008, 1, m(4),    32'h3010, 32'h3008, 5,  0);
        add(0, 1, 32'h3020, 1, m(2),    32'h3008, 32'h3020, 6,  0);
        add(0, 0, 32'h0,    1, m(8),    32'h3020, 32'h3024, 7,  0);
        add(1, 1, 32'h3010, 1, m(9),    32'h3024, 32'h3010, 8,  0);
        add(0, 0, 32'h0,    1, m(4),    32'h3010, 32'h3014, 9,  0);
        add(0, 1, 32'h0,    1, m(5),    32'h3014, 32'h0000, 10, 0);
        add(0, 0, 32'h0,    0, 32'h0,   32'h0,    32'h0000, 10, 1);
        add(0, 0, 32'h0,    0, 32'h0,   32'h0,    32'h0000, 10, 1);
        add(1, 0, 32'h0,    0, 32'h0,   32'h0,    32'h0000, 10, 1);
        add(0, 1, 32'h3001, 0, 32'h0,   32'h0,    32'h3000, 10, 1);
        add(0, 0, 32'h0,    1, m(0),    32'h3000, 32'h3004, 11, 1);
        add(0, 1, 32'h3FFC, 1, m(1),    32'h3004, 32'h3FFC, 12, 1);
        add(0, 0, 32'h0,    1, m(1023), 32'h3FFC, 32'h4000, 13, 1);
        add(0, 0, 32'h0,    0, 32'h0,   32'h0,    32'h4000, 13, 1);
        add(0, 1, 32'h3000, 0, 32'h0,   32'h0,    32'h3000, 13, 1);
        add(0, 0, 32'h0,    1, m(0),    32'h3000, 32'h3004, 14, 1);

        for (int i = 0; i < vq.size(); i++) begin
            stall = vq[i].stall; redirect = vq[i].redir; redirect_pc = vq[i].rpc;
            @(posedge clock); #1;
            exp_addr = (vq[i].pc - 32'h0000_3000) >> 2;
            chk($sformatf("v%0d valid", i), 32'(b1.if_id_valid), 32'(vq[i].valid));
            chk($sformatf("v%0d instr", i), b1.if_id_instr, vq[i].instr);
            chk($sformatf("v%0d ifpc", i),  b1.if_id_pc, vq[i].ipc);
            chk($sformatf("v%0d pc4", i),   b1.if_id_pc4, vq[i].valid ? vq[i].ipc + 32'd4 : 32'h0);
            chk($sformatf("v%0d pc", i),    b1.pc, vq[i].pc);
            chk($sformatf("v%0d imem_addr", i), 32'(b1.imem_addr), {22'h0, exp_addr[9:0]});
            chk($sformatf("v%0d count", i), b1.fetch_count, vq[i].cnt);
            chk($sformatf("v%0d fault", i), 32'(b1.pc_fault), 32'(vq[i].fault));
            // Without a delay slot every redirect edge squashes the fetch.
            chk($sformatf("v%0d ds0 valid", i), 32'(b0.if_id_valid), 32'(vq[i].valid && !vq[i].redir));
            chk($sformatf("v%0d ds0 instr", i), b0.if_id_instr, vq[i].redir ? 32'h0 : vq[i].instr);
            chk($sformatf("v%0d ds0 pc", i),    b0.pc, vq[i].pc);
        end

        // Reset mid-run must beat a simultaneous stall and redirect.
        reset = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_3020;
        @(posedge clock); #1;
        chk_reset_state("midrun reset");

        // First fetch after reset release.
        reset = 1'b0; stall = 1'b0; redirect = 1'b0;
        @(posedge clock); #1;
        chk("post reset instr", b1.if_id_instr, m(0));
        chk("post reset count", b1.fetch_count, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
